// File: rtl/avs_i2s_pkg.sv
// Shared register map, bit positions and serializer state encoding for the
// Avalon-MM I2S transmitter.
package avs_i2s_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_CONTROL = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CLKDIV  = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_MONO   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_FLUSH  = 3;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_UNDERRUN  = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_LEVEL_LSB = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_e;

endpackage

// File: rtl/avs_i2s_fifo.sv
// Synchronous sample FIFO with flush, occupancy level and a peekable head.
// Push on full and pop on empty are ignored; flush wins over both.
module avs_i2s_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          full_s;
  logic          empty_s;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_s    = (level_r == LW'(DEPTH));
  assign empty_s   = (level_r == LW'(0));
  assign do_push_s = push & ~full_s;
  assign do_pop_s  = pop & ~empty_s;

  assign full  = full_s;
  assign empty = empty_s;
  assign level = level_r;
  assign head  = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r <= level_r + LW'(do_push_s) - LW'(do_pop_s);
    end
  end

  // Sample storage.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/avs_i2s_tx.sv
// Avalon-MM slave I2S transmitter: register file, SCK divider and MSB-first
// serializer draining a sample FIFO in stereo (L,R) or mono (L repeated) order.
module avs_i2s_tx
  import avs_i2s_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  output logic        avs_s0_waitrequest,
  output logic [31:0] avs_s0_readdata,
  input  logic [31:0] avs_s0_writedata,
  output logic        avs_s0_irq,
  output logic        avs_s0_export_i2s_sck,
  output logic        avs_s0_export_i2s_sd,
  output logic        avs_s0_export_i2s_ws
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(DW);

  logic            en_r, mono_r, irq_en_r, irq_r;
  logic            underrun_r, overflow_r;
  logic [15:0]     clkdiv_r;
  i2s_state_e      state_r, state_next_s;
  logic [15:0]     div_cnt_r;
  logic [BW-1:0]   bit_cnt_r;
  logic            sck_r, sd_r, ws_r;
  logic [DW-1:0]   shift_r, word_r;

  logic            wr_data_s, wr_ctrl_s, wr_stat_s, wr_div_s;
  logic            en_next_s, run_s, tc_s, fall_tick_s, load_s, reuse_s;
  logic            push_s, pop_s, flush_s, underrun_set_s, overflow_set_s;
  logic            fifo_full_s, fifo_empty_s;
  logic [LW-1:0]   fifo_level_s;
  logic [DW-1:0]   fifo_head_s, load_word_s;
  logic [31:0]     status_s, rdata_s;
  logic            unused_s;

  assign wr_data_s = avs_s0_write & (avs_s0_address == ADDR_DATA);
  assign wr_ctrl_s = avs_s0_write & (avs_s0_address == ADDR_CONTROL);
  assign wr_stat_s = avs_s0_write & (avs_s0_address == ADDR_STATUS);
  assign wr_div_s  = avs_s0_write & (avs_s0_address == ADDR_CLKDIV);

  assign push_s         = wr_data_s & ~fifo_full_s;
  assign overflow_set_s = wr_data_s & fifo_full_s & ~en_r;
  assign flush_s        = wr_ctrl_s & avs_s0_writedata[CTRL_FLUSH];
  assign unused_s       = ^avs_s0_writedata;

  // Shrinking N below the running count terminates the half-period at once.
  assign run_s       = (state_r == RUN) & (state_next_s == RUN);
  assign tc_s        = (div_cnt_r >= clkdiv_r);
  assign fall_tick_s = run_s & tc_s & sck_r;
  assign load_s      = fall_tick_s & (bit_cnt_r == BW'(0));
  assign reuse_s     = mono_r & ws_r;
  assign pop_s       = load_s & ~reuse_s;
  assign underrun_set_s = pop_s & fifo_empty_s;
  assign load_word_s = reuse_s ? word_r : (fifo_empty_s ? DW'(0) : fifo_head_s);

  assign avs_s0_waitrequest    = wr_data_s & fifo_full_s & en_r;
  assign avs_s0_readdata       = rdata_s;
  assign avs_s0_irq            = irq_r;
  assign avs_s0_export_i2s_sck = sck_r;
  assign avs_s0_export_i2s_sd  = sd_r;
  assign avs_s0_export_i2s_ws  = ws_r;

  avs_i2s_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data (avs_s0_writedata[DW-1:0]),
    .pop       (pop_s),
    .flush     (flush_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level_s),
    .head      (fifo_head_s)
  );

  // Next state follows EN including a CONTROL write in flight.
  always_comb begin
    state_next_s = state_r;
    if (wr_ctrl_s) begin
      en_next_s = avs_s0_writedata[CTRL_EN];
    end else begin
      en_next_s = en_r;
    end
    case (state_r)
      IDLE:    state_next_s = en_next_s ? RUN : IDLE;
      RUN:     state_next_s = en_next_s ? RUN : IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Control registers, sticky flags and registered interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_r       <= 1'b0;
      mono_r     <= 1'b0;
      irq_en_r   <= 1'b0;
      clkdiv_r   <= 16'd0;
      underrun_r <= 1'b0;
      overflow_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        en_r     <= avs_s0_writedata[CTRL_EN];
        mono_r   <= avs_s0_writedata[CTRL_MONO];
        irq_en_r <= avs_s0_writedata[CTRL_IRQ_EN];
      end
      if (wr_div_s) clkdiv_r <= avs_s0_writedata[15:0];
      if (underrun_set_s) underrun_r <= 1'b1;
      else if (wr_stat_s && avs_s0_writedata[STAT_UNDERRUN]) underrun_r <= 1'b0;
      if (overflow_set_s) overflow_r <= 1'b1;
      else if (wr_stat_s && avs_s0_writedata[STAT_OVERFLOW]) overflow_r <= 1'b0;
      irq_r <= irq_en_r & ((fifo_level_s <= LW'(DEPTH / 2)) | underrun_r);
    end
  end

  // Divider and serializer; a falling SCK tick advances one bit of the slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r <= 16'd0;
      bit_cnt_r <= BW'(0);
      sck_r     <= 1'b0;
      sd_r      <= 1'b0;
      ws_r      <= 1'b0;
      shift_r   <= DW'(0);
      word_r    <= DW'(0);
    end else if (!run_s) begin
      div_cnt_r <= 16'd0;
      bit_cnt_r <= BW'(0);
      sck_r     <= 1'b0;
      sd_r      <= 1'b0;
      ws_r      <= 1'b0;
      shift_r   <= DW'(0);
    end else if (tc_s) begin
      div_cnt_r <= 16'd0;
      sck_r     <= ~sck_r;
      if (sck_r) begin
        if (load_s) begin
          sd_r    <= load_word_s[DW-1];
          shift_r <= {load_word_s[DW-2:0], 1'b0};
          word_r  <= load_word_s;
        end else begin
          sd_r    <= shift_r[DW-1];
          shift_r <= {shift_r[DW-2:0], 1'b0};
        end
        if (bit_cnt_r == BW'(DW - 1)) begin
          ws_r      <= ~ws_r;
          bit_cnt_r <= BW'(0);
        end else begin
          bit_cnt_r <= bit_cnt_r + BW'(1);
        end
      end
    end else begin
      div_cnt_r <= div_cnt_r + 16'd1;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    status_s = 32'd0;
    status_s[STAT_FULL]     = fifo_full_s;
    status_s[STAT_EMPTY]    = fifo_empty_s;
    status_s[STAT_UNDERRUN] = underrun_r;
    status_s[STAT_OVERFLOW] = overflow_r;
    status_s[31:STAT_LEVEL_LSB] = 16'(fifo_level_s);
    rdata_s = 32'd0;
    if (avs_s0_read) begin
      case (avs_s0_address)
        ADDR_DATA:    rdata_s = fifo_empty_s ? 32'd0 : 32'(fifo_head_s);
        ADDR_CONTROL: rdata_s = {29'd0, irq_en_r, mono_r, en_r};
        ADDR_STATUS:  rdata_s = status_s;
        ADDR_CLKDIV:  rdata_s = {16'd0, clkdiv_r};
        default:      rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

endmodule

// File: tb/tb_avs_i2s_tx.sv
// Scoreboard bench for avs_i2s_tx: register reads and serial bits are queued
// as expectations and compared by independent monitors.
module tb_avs_i2s_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam logic [1:0] A_DATA = 2'd0, A_CTRL = 2'd1, A_STAT = 2'd2, A_DIV = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic        waitrequest, irq, sck, sd, ws;
  logic [31:0] readdata;

  int checks = 0;
  int failures = 0;
  int bit_idx = 0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [1:0]  bit_q[$];
  logic        sck_prev = 1'b0;

  avs_i2s_tx #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .avs_s0_address        (address),
    .avs_s0_read           (read),
    .avs_s0_write          (write),
    .avs_s0_waitrequest    (waitrequest),
    .avs_s0_readdata       (readdata),
    .avs_s0_writedata      (writedata),
    .avs_s0_irq            (irq),
    .avs_s0_export_i2s_sck (sck),
    .avs_s0_export_i2s_sd  (sd),
    .avs_s0_export_i2s_ws  (ws)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Read monitor: every strobed read consumes one queued expectation.
  always @(negedge clk) begin
    if (read) begin
      if (rd_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=0x%08h", readdata);
      end else begin
        chk(rd_name_q.pop_front(), readdata, rd_exp_q.pop_front());
      end
    end
  end

  // Serial monitor: {ws,sd} at each SCK rise against the queued bit stream.
  always @(negedge clk) begin
    if (reset_n && sck && !sck_prev && bit_q.size() > 0) begin
      chk($sformatf("serial_bit%0d", bit_idx), {30'd0, ws, sd}, {30'd0, bit_q[0]});
      void'(bit_q.pop_front());
      bit_idx++;
    end
    sck_prev <= sck;
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int stall);
    stall = 0;
    @(posedge clk); #1;
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    while (waitrequest && stall < 1000) begin
      stall++;
      @(negedge clk);
    end
    if (stall >= 1000) begin
      checks++;
      failures++;
      $display("FAIL write_timeout stall=%0d limit=1000", stall);
    end
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    int s;
    bus_write(a, d, s);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    address = a; read = 1'b1;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] w, input logic slot_ws);
    for (int k = 0; k < DW; k++) begin
      bit_q.push_back({(k == DW - 1) ? ~slot_ws : slot_ws, w[DW-1-k]});
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (bit_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, bit_q.size(), 32'd0);
    bit_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int stall;
    int cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_outputs", {27'd0, sck, sd, ws, irq, waitrequest}, 32'd0);
    chk("rst_readdata_idle", readdata, 32'd0);
    rd(A_STAT, 32'h0000_0002, "rst_status");
    rd(A_DIV,  32'h0000_0000, "rst_clkdiv");
    rd(A_CTRL, 32'h0000_0000, "rst_control");

    // Stereo stream with N=1, followed by an underrun slot of zeros.
    wr(A_DIV, 32'd1);
    rd(A_DIV, 32'd1, "clkdiv_readback");
    wr(A_DATA, 32'h0000_A5A5);
    wr(A_DATA, 32'h0000_3C3C);
    rd(A_STAT, 32'h0002_0000, "prefill_status");
    rd(A_DATA, 32'h0000_A5A5, "data_peek");
    bit_q.push_back(2'b00);
    push_word(16'hA5A5, 1'b0);
    push_word(16'h3C3C, 1'b1);
    push_word(16'h0000, 1'b0);
    wr(A_CTRL, 32'h1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!sck && cnt < 100);
    chk("first_sck_rise_clks", cnt - 1, 32'd2);
    wait_drain("stream_stereo_drained", 2000);
    rd(A_STAT, 32'h0000_0006, "underrun_status");
    chk("irq_disabled", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h4);
    rd(A_STAT, 32'h0000_0002, "underrun_cleared");

    // Full FIFO while running: write stalls until the first pop at 2(N+1).
    wr(A_DIV, 32'd7);
    for (int i = 0; i < DEPTH; i++) wr(A_DATA, 32'h100 + i);
    rd(A_STAT, 32'h0010_0001, "full_status");
    wr(A_CTRL, 32'h1);
    bus_write(A_DATA, 32'h1FF, stall);
    chk("waitrequest_stall_cycles", stall, 32'd15);
    rd(A_STAT, 32'h0010_0001, "stalled_write_completed");
    wr(A_CTRL, 32'h8);
    rd(A_STAT, 32'h0000_0002, "flush_idle_status");

    // Full FIFO while idle: write dropped, OVERFLOW set, no stall.
    for (int i = 0; i < DEPTH; i++) wr(A_DATA, 32'h200 + i);
    bus_write(A_DATA, 32'h2FF, stall);
    chk("overflow_no_stall", stall, 32'd0);
    rd(A_STAT, 32'h0010_0009, "overflow_status");
    rd(A_DATA, 32'h0000_0200, "overflow_head_kept");
    wr(A_STAT, 32'h8);
    rd(A_STAT, 32'h0010_0001, "overflow_cleared");
    wr(A_CTRL, 32'h8);

    // Mono, N=0: each word appears in both slots, one pop per frame.
    wr(A_DIV, 32'd0);
    wr(A_DATA, 32'h1234);
    rd(A_STAT, 32'h0001_0000, "mono_level1");
    wr(A_DATA, 32'hBEEF);
    bit_q.push_back(2'b00);
    push_word(16'h1234, 1'b0);
    push_word(16'h1234, 1'b1);
    push_word(16'hBEEF, 1'b0);
    push_word(16'hBEEF, 1'b1);
    wr(A_CTRL, 32'h3);
    wait_drain("stream_mono_drained", 2000);
    repeat (20) @(negedge clk);
    wr(A_CTRL, 32'h0);
    rd(A_STAT, 32'h0000_0006, "mono_drained_status");
    wr(A_STAT, 32'h4);

    // Flush with LEVEL=5 while running, before the first pop.
    wr(A_DIV, 32'd15);
    for (int i = 0; i < 5; i++) wr(A_DATA, 32'h300 + i);
    rd(A_STAT, 32'h0005_0000, "flush_pre_level");
    bit_q.push_back(2'b00);
    push_word(16'h0000, 1'b0);
    wr(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h9);
    rd(A_STAT, 32'h0000_0002, "flush_level0");
    wait_drain("stream_flush_drained", 4000);
    rd(A_STAT, 32'h0000_0006, "flush_underrun");
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h4);
    rd(A_STAT, 32'h0000_0002, "flush_underrun_cleared");

    // Interrupt threshold at DEPTH/2, then reset mid-frame.
    wr(A_DIV, 32'd1);
    wr(A_CTRL, 32'h4);
    repeat (2) @(negedge clk);
    chk("irq_empty", {31'd0, irq}, 32'd1);
    for (int i = 0; i < DEPTH / 2; i++) wr(A_DATA, 32'h400 + i);
    repeat (2) @(negedge clk);
    chk("irq_half_level", {31'd0, irq}, 32'd1);
    rd(A_STAT, 32'h0008_0000, "half_status");
    wr(A_DATA, 32'h4FF);
    repeat (2) @(negedge clk);
    chk("irq_above_half", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 32'h5);
    repeat (30) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {27'd0, sck, sd, ws, irq, waitrequest}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rd(A_STAT, 32'h0000_0002, "rst_mid_status");
    rd(A_CTRL, 32'h0000_0000, "rst_mid_control");
    rd(A_DIV,  32'h0000_0000, "rst_mid_clkdiv");

    repeat (2) @(negedge clk);
    chk("rd_queue_empty", rd_exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avs_i2s_tx.md
# avs_i2s_tx

Avalon-MM slave I2S transmitter; parametrised successor of the single-register I2S slave. Adds a sample FIFO, stereo and mono modes, and a programmable SCK divider. Adds waitrequest back-pressure, sticky error flags and an interrupt. Sits on the system Avalon bus and drives an external DAC through the exported SCK/SD/WS pins.

## Interface
- DW, 16: sample width in bits, 16..32; SD carries DW bits per channel slot.
- DEPTH, 16: FIFO depth in samples, power of two, 4..256.
- clk  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- avs_s0_address  in  2  word address: 0 DATA, 1 CONTROL, 2 STATUS, 3 CLKDIV.
- avs_s0_read  in  1  read strobe.
- avs_s0_write  in  1  write strobe.
- avs_s0_waitrequest  out  1  write stall when the FIFO is full.
- avs_s0_readdata  out  32  read data, zero-latency (combinational), 0 when not reading.
- avs_s0_writedata  in  32  write data.
- avs_s0_irq  out  1  level interrupt.
- avs_s0_export_i2s_sck  out  1  serial bit clock.
- avs_s0_export_i2s_sd  out  1  serial data, MSB first.
- avs_s0_export_i2s_ws  out  1  word select: 0 = left, 1 = right.

## Operation
- DATA write pushes writedata[DW-1:0] into the FIFO. DATA reads the FIFO head without popping; it returns 0 when empty.
- CONTROL bits: [0] EN, [1] MONO, [2] IRQ_EN. Bit [3] FLUSH is self-clearing and always reads 0. Reset value is 0.
- STATUS bits: [0] FULL, [1] EMPTY, [2] UNDERRUN (sticky), [3] OVERFLOW (sticky), [31:16] LEVEL.
  - Writing 1 to bit 2 or bit 3 clears that flag; other STATUS bits are read-only.
- CLKDIV: [15:0] N. SCK half-period is N+1 clk cycles. Reset value is 0 (SCK = clk/2).
- Full FIFO on a DATA write:
  - EN=1: waitrequest asserts the same cycle and holds until a pop frees space. The write then completes.
  - EN=0: the write is dropped, OVERFLOW is set, and waitrequest stays 0.
- Waitrequest is 0 for all other accesses.
- States are IDLE (EN=0) and RUN (EN=1).
  - IDLE: divider and bit counter cleared; sck=0, ws=0, sd=0. FIFO contents are retained, so software can prefill before enabling.
- RUN: the divider counts 0..N; at terminal count sck toggles and the counter reloads. Compare is counter>=N, so a shrunk N takes effect immediately.
- Falling-edge tick k of a slot (k = 0..DW-1) drives sd = word[DW-1-k].
  - At k=0 the word is loaded from the FIFO, which is a pop.
  - At k=DW-1 ws toggles. This gives the standard I2S one-bit WS lead; IDLE's ws=0 acts as the lead for the first left word.
- Stereo mode pops at k=0 of every slot. FIFO order is L, R, L, R.
- MONO mode pops only at k=0 of the left slot; the right slot retransmits the same word.
- Pop from an empty FIFO loads 0 and sets UNDERRUN; the frame continues.
- FLUSH empties the FIFO the cycle after the write, with LEVEL=0. FLUSH wins over a pop in the same cycle.
- Clearing EN mid-frame returns to IDLE on the next clk. The partial word is discarded and not re-queued.
- irq = IRQ_EN & (LEVEL <= DEPTH/2 | UNDERRUN).

## Timing
- Push is visible in LEVEL/STATUS on the cycle after the accepted write.
- Push and pop in the same cycle leave LEVEL unchanged.
- EN 0→1: first sck rise is N+1 clks after the EN write, and the first falling tick is 2(N+1) clks after.
- Frame = 2·DW sck periods = 4·DW·(N+1) clks.
- Reset values: sck=0, sd=0, ws=0, irq=0, waitrequest=0, readdata=0, FIFO empty.

## Structure
- Package avs_i2s_pkg: register address constants (ADDR_DATA..ADDR_CLKDIV), CONTROL/STATUS bit-position constants, and the state enum {IDLE, RUN}.
- Sub-module avs_i2s_fifo: synchronous FIFO (DW, DEPTH) with push, pop, flush, full, empty, level, and a head-data output.
- Top level contains the register file, divider and serializer.

## Test plan
- Reset: all outputs 0; STATUS reads 0x00000002 (EMPTY); CLKDIV reads 0.
- DW=16, N=1: prefill 0xA5A5 and 0x3C3C, set EN → sd shows 1010010110100101 on the left slot and 0011110000111100 on the right. WS changes one SCK before each MSB; UNDERRUN is then set with zeros transmitted.
- Fill DEPTH words with EN=1, write one more → waitrequest held until the first pop, after which the write completes. Repeat with EN=0 → write dropped and OVERFLOW=1.
- MONO with one word 0x1234 → left and right slots both carry 0x1234; LEVEL goes 1→0 with a single pop.
- FLUSH with LEVEL=5 while running → LEVEL=0 next cycle; the next slot transmits 0 and sets UNDERRUN. Write-1 to STATUS bit 2 clears it.
- Assert reset_n low mid-frame → outputs go to 0 immediately, FIFO empty, CONTROL=0. IRQ_EN with LEVEL=DEPTH/2 → irq=1.
